mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Two-master round-robin arbiter that shares one picorv32-native memory port, e.g. the memory controller, between two requesters such as two picorv32 cores or a core plus a loader/DMA. Each master sees a normal valid/ready bus. The arbiter owns the shared port, forwards one transaction at a time, and never interleaves within a transaction. It sits between the cores and the memory/peripheral decode.

Parameters:
TIMEOUT_CYCLES, 255, cycles a granted transaction may wait for s_mem_ready before forced completion (only used with ARB_TIMEOUT_EN).
FIRST_GRANT, 0, master that wins the first simultaneous request after reset (0 or 1).

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
m0_mem_valid  input  1  master 0 request
m0_mem_instr  input  1  master 0 instruction-fetch flag
m0_mem_wstrb  input  4  master 0 byte write strobes, 0 = read
m0_mem_addr  input  32  master 0 byte address
m0_mem_wdata  input  32  master 0 write data
m0_mem_ready  output  1  master 0 transaction complete
m0_mem_rdata  output  32  master 0 read data
m1_mem_valid, m1_mem_instr, m1_mem_wstrb, m1_mem_addr, m1_mem_wdata, m1_mem_ready, m1_mem_rdata  same as m0 for master 1
s_mem_valid  output  1  shared port request
s_mem_instr  output  1  shared port instr flag
s_mem_wstrb  output  4  shared port strobes
s_mem_addr  output  32  shared port address
s_mem_wdata  output  32  shared port write data
s_mem_ready  input  1  shared port complete
s_mem_rdata  input  32  shared port read data
grant  output  2  one-hot current owner, 00 when idle
timeout_err  output  1  one-cycle pulse on forced completion

Behaviour:
- Reset (async, immediate): state=IDLE, grant=00, last=~FIRST_GRANT, s_mem_valid=0, m0/m1_mem_ready=0, timeout_err=0, timeout counter=0. A transaction cut by reset is abandoned; the slave sees s_mem_valid fall in the same instant.
- States: IDLE, GNT0, GNT1, RELEASE.
- IDLE: if only mX_mem_valid, go to GNTX next edge. If both, go to the master != last. If none, stay. Grant is registered: a request seen in cycle N drives the shared port from cycle N+1, so minimum added latency is 1 cycle.
- GNTX: s_mem_* = mX_mem_* combinationally. s_mem_valid = mX_mem_valid. mX_mem_ready = s_mem_ready. Other master's ready=0. Both mX_mem_rdata = s_mem_rdata; only the granted master gets ready. On s_mem_ready=1: last<=X, go to RELEASE.
- RELEASE: one dead cycle. s_mem_valid=0 and both readys 0, so a master still holding valid after ready is not re-issued. Go to IDLE.
- Back-to-back: a master requesting continuously is served every 3 cycles minimum when the slave is zero-wait. With both requesting, grants strictly alternate.
- Granted master dropping valid before ready (protocol violation): s_mem_valid follows it low. The arbiter stays in GNTX until s_mem_ready.
- s_mem_ready in IDLE/RELEASE is ignored.
- Outside GNTX: s_mem_addr/wdata/wstrb/instr = 0.

Optional Feature:
ARB_TIMEOUT_EN
- Defined: a counter clears on entering GNTX and increments each GNTX cycle without s_mem_ready. When it reaches TIMEOUT_CYCLES, for one cycle mX_mem_ready=1, mX_mem_rdata=32'hDEADBEEF, s_mem_valid=0 and timeout_err=1. Then go to RELEASE with last<=X. s_mem_ready arriving in that same cycle wins: normal completion, no error.
- Undefined: no counter; GNTX waits indefinitely; timeout_err tied 0.

Test Plan:
- Reset then m0 read of 0x0000_0010, slave returns 0x1234_5678 with zero wait: grant=01 in cycle 1, m0_mem_ready with rdata 0x1234_5678, RELEASE, grant=00.
- m0 and m1 both request the same cycle after reset (FIRST_GRANT=0): m0 served first, then m1. Repeated requests alternate 01,10,01,10.
- m1 write wstrb=4'b0011 addr 0x100 data 0xAABBCCDD with 3 slave wait states: s_mem_* mirror m1 for 4 cycles, m0 ready stays 0, m1_mem_ready on cycle 4 only.
- m0 holds valid one cycle past ready: no second slave access; s_mem_valid=0 in RELEASE.
- Assert reset during GNT1 with slave stalled: s_mem_valid, grant and readys drop to 0 without a clock edge; next request is arbitrated from IDLE.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never ready: m0 gets ready with 0xDEADBEEF on cycle 8 of grant, timeout_err pulses once, and m1 is then served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Two-master round-robin arbiter sharing one picorv32-native memory port.
// One transaction is forwarded at a time and never interleaved. A granted
// transaction is followed by one dead RELEASE cycle. This keeps a master
// that still holds valid after its ready from being issued a second time.
//
// Optional build macro: ARB_TIMEOUT_EN
//   When defined, a stalled grant is force-completed after TIMEOUT_CYCLES
//   grant cycles. The granted master then receives ready with 32'hDEADBEEF,
//   and timeout_err pulses for one cycle. When undefined, a grant waits
//   indefinitely and timeout_err is tied low.
//
// Parameters:
//   TIMEOUT_CYCLES  grant cycles before forced completion (timeout build only)
//   FIRST_GRANT     master that wins the first simultaneous request
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   m0_mem_* / m1_mem_*        master-side valid/instr/wstrb/addr/wdata in,
//                              ready/rdata out
//   s_mem_*                    shared port: valid/instr/wstrb/addr/wdata out,
//                              ready/rdata in
//   grant                      one-hot current owner, 2'b00 when not granted
//   timeout_err                one-cycle pulse on forced completion
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned FIRST_GRANT    = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_mem_valid,
    input  logic        m0_mem_instr,
    input  logic [3:0]  m0_mem_wstrb,
    input  logic [31:0] m0_mem_addr,
    input  logic [31:0] m0_mem_wdata,
    output logic        m0_mem_ready,
    output logic [31:0] m0_mem_rdata,
    input  logic        m1_mem_valid,
    input  logic        m1_mem_instr,
    input  logic [3:0]  m1_mem_wstrb,
    input  logic [31:0] m1_mem_addr,
    input  logic [31:0] m1_mem_wdata,
    output logic        m1_mem_ready,
    output logic [31:0] m1_mem_rdata,
    output logic        s_mem_valid,
    output logic        s_mem_instr,
    output logic [3:0]  s_mem_wstrb,
    output logic [31:0] s_mem_addr,
    output logic [31:0] s_mem_wdata,
    input  logic        s_mem_ready,
    input  logic [31:0] s_mem_rdata,
    output logic [1:0]  grant,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GNT0    = 2'b01,
        GNT1    = 2'b10,
        RELEASE = 2'b11
    } state_t;

    state_t state_r;
    state_t state_next_s;
    logic   last_r;        // master that completed most recently
    logic   last_next_s;
    logic   timeout_hit_s; // forced completion of the current grant this cycle

`ifdef ARB_TIMEOUT_EN
    logic [31:0] tmo_cnt_r;

    // Timeout counter: cleared whenever no grant is active, counts stalled grant cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_r <= 32'd0;
        end else if ((state_r == GNT0) || (state_r == GNT1)) begin
            if (!s_mem_ready) begin
                tmo_cnt_r <= tmo_cnt_r + 32'd1;
            end else begin
                tmo_cnt_r <= tmo_cnt_r;
            end
        end else begin
            tmo_cnt_r <= 32'd0;
        end
    end

    // The count reads k-1 in grant cycle k, so the hit lands on grant cycle
    // TIMEOUT_CYCLES. A slave ready in the same cycle takes priority.
    assign timeout_hit_s = ((state_r == GNT0) || (state_r == GNT1)) && !s_mem_ready &&
                           (tmo_cnt_r == 32'(TIMEOUT_CYCLES - 32'd1));
`else
    // TIMEOUT_CYCLES has no effect when the timeout is not compiled in.
    assign timeout_hit_s = (TIMEOUT_CYCLES == 32'd0) && 1'b0;
`endif

    assign timeout_err = timeout_hit_s;

    // The grant decodes straight from the state register, so it never glitches.
    assign grant = {(state_r == GNT1), (state_r == GNT0)};

    // State and round-robin history registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            last_r  <= (FIRST_GRANT == 32'd0) ? 1'b1 : 1'b0;
        end else begin
            state_r <= state_next_s;
            last_r  <= last_next_s;
        end
    end

    // Next-state logic and shared-port / master-side output muxing.
    always_comb begin
        state_next_s = state_r;
        last_next_s  = last_r;
        s_mem_valid  = 1'b0;
        s_mem_instr  = 1'b0;
        s_mem_wstrb  = 4'b0000;
        s_mem_addr   = 32'd0;
        s_mem_wdata  = 32'd0;
        m0_mem_ready = 1'b0;
        m1_mem_ready = 1'b0;
        m0_mem_rdata = s_mem_rdata;
        m1_mem_rdata = s_mem_rdata;
        case (state_r)
            IDLE: begin
                if (m0_mem_valid && m1_mem_valid) begin
                    state_next_s = last_r ? GNT0 : GNT1;
                end else if (m0_mem_valid) begin
                    state_next_s = GNT0;
                end else if (m1_mem_valid) begin
                    state_next_s = GNT1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            GNT0: begin
                // Valid follows the master even if it drops early. The grant
                // is held until the slave or the timeout completes it.
                s_mem_valid  = m0_mem_valid & ~timeout_hit_s;
                s_mem_instr  = m0_mem_instr;
                s_mem_wstrb  = m0_mem_wstrb;
                s_mem_addr   = m0_mem_addr;
                s_mem_wdata  = m0_mem_wdata;
                m0_mem_ready = s_mem_ready | timeout_hit_s;
                if (timeout_hit_s) begin
                    m0_mem_rdata = 32'hDEAD_BEEF;
                end else begin
                    m0_mem_rdata = s_mem_rdata;
                end
                if (s_mem_ready || timeout_hit_s) begin
                    state_next_s = RELEASE;
                    last_next_s  = 1'b0;
                end else begin
                    state_next_s = GNT0;
                end
            end
            GNT1: begin
                s_mem_valid  = m1_mem_valid & ~timeout_hit_s;
                s_mem_instr  = m1_mem_instr;
                s_mem_wstrb  = m1_mem_wstrb;
                s_mem_addr   = m1_mem_addr;
                s_mem_wdata  = m1_mem_wdata;
                m1_mem_ready = s_mem_ready | timeout_hit_s;
                if (timeout_hit_s) begin
                    m1_mem_rdata = 32'hDEAD_BEEF;
                end else begin
                    m1_mem_rdata = s_mem_rdata;
                end
                if (s_mem_ready || timeout_hit_s) begin
                    state_next_s = RELEASE;
                    last_next_s  = 1'b1;
                end else begin
                    state_next_s = GNT1;
                end
            end
            RELEASE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. Stimulus pushes the expected completion
// (master id and read data) into a queue. A monitor pops an entry and
// compares it whenever a master-side ready appears. A simple slave model
// answers after a programmable number of wait states. It returns
// slave_rdata XOR address so that every expected value is fixed by hand.
// Inputs change 1 time unit after the rising edge. The slave reacts
// 2 units after the edge. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_mem_valid, m0_mem_instr, m0_mem_ready;
    logic [3:0]  m0_mem_wstrb;
    logic [31:0] m0_mem_addr, m0_mem_wdata, m0_mem_rdata;
    logic        m1_mem_valid, m1_mem_instr, m1_mem_ready;
    logic [3:0]  m1_mem_wstrb;
    logic [31:0] m1_mem_addr, m1_mem_wdata, m1_mem_rdata;
    logic        s_mem_valid, s_mem_instr, s_mem_ready;
    logic [3:0]  s_mem_wstrb;
    logic [31:0] s_mem_addr, s_mem_wdata, s_mem_rdata;
    logic [1:0]  grant;
    logic        timeout_err;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          slave_wait = 0;
    logic [31:0] slave_rdata = 32'd0;
    int          slave_acc = 0;
    int          tmo_pulses = 0;
    bit          exp_m_q[$];
    logic [31:0] exp_d_q[$];

    mem_arbiter #(.TIMEOUT_CYCLES(8), .FIRST_GRANT(0)) dut (
        .clk(clk), .reset(reset),
        .m0_mem_valid(m0_mem_valid), .m0_mem_instr(m0_mem_instr), .m0_mem_wstrb(m0_mem_wstrb),
        .m0_mem_addr(m0_mem_addr), .m0_mem_wdata(m0_mem_wdata),
        .m0_mem_ready(m0_mem_ready), .m0_mem_rdata(m0_mem_rdata),
        .m1_mem_valid(m1_mem_valid), .m1_mem_instr(m1_mem_instr), .m1_mem_wstrb(m1_mem_wstrb),
        .m1_mem_addr(m1_mem_addr), .m1_mem_wdata(m1_mem_wdata),
        .m1_mem_ready(m1_mem_ready), .m1_mem_rdata(m1_mem_rdata),
        .s_mem_valid(s_mem_valid), .s_mem_instr(s_mem_instr), .s_mem_wstrb(s_mem_wstrb),
        .s_mem_addr(s_mem_addr), .s_mem_wdata(s_mem_wdata),
        .s_mem_ready(s_mem_ready), .s_mem_rdata(s_mem_rdata),
        .grant(grant), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_xfer(input bit m, input logic [31:0] d);
        exp_m_q.push_back(m);
        exp_d_q.push_back(d);
    endtask

    // Slave model: zero-based wait counter, ready held for exactly one cycle.
    initial begin
        int wcnt;
        wcnt = 0;
        s_mem_ready = 1'b0;
        s_mem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                s_mem_ready = 1'b0;
                wcnt = 0;
            end else if (s_mem_ready) begin
                s_mem_ready = 1'b0;
            end else if (s_mem_valid) begin
                if (wcnt >= slave_wait) begin
                    s_mem_ready = 1'b1;
                    s_mem_rdata = slave_rdata ^ s_mem_addr;
                    slave_acc++;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Monitor: every master-side ready must match the oldest expected completion.
    initial forever begin
        bit          m;
        logic [31:0] rd;
        @(negedge clk);
        if (timeout_err === 1'b1) tmo_pulses++;
        if (m0_mem_ready && m1_mem_ready) check("both readies", 32'd1, 32'd0);
        if (m0_mem_ready || m1_mem_ready) begin
            m  = m1_mem_ready;
            rd = m ? m1_mem_rdata : m0_mem_rdata;
            if (exp_m_q.size() == 0) begin
                check("unexpected ready", 32'(m), 32'hFFFF_FFFF);
            end else begin
                check("xfer master", 32'(m), 32'(exp_m_q.pop_front()));
                check("xfer rdata", rd, exp_d_q.pop_front());
            end
        end
    end

    task automatic do_reset();
        tick();
        reset = 1'b1;
        m0_mem_valid = 1'b0;
        m1_mem_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, seen, last_cyc, acc0, gc;
        reset = 1'b1;
        m0_mem_valid = 1'b0; m0_mem_instr = 1'b0; m0_mem_wstrb = 4'h0;
        m0_mem_addr = 32'd0; m0_mem_wdata = 32'd0;
        m1_mem_valid = 1'b0; m1_mem_instr = 1'b0; m1_mem_wstrb = 4'h0;
        m1_mem_addr = 32'd0; m1_mem_wdata = 32'd0;

        // Reset state
        #12;
        check("reset grant", 32'(grant), 32'd0);
        check("reset s_valid", 32'(s_mem_valid), 32'd0);
        check("reset readies", 32'({m0_mem_ready, m1_mem_ready}), 32'd0);
        check("reset timeout_err", 32'(timeout_err), 32'd0);
        tick();
        reset = 1'b0;

        // Test 1: single zero-wait m0 read
        tick();
        slave_wait = 0;
        slave_rdata = 32'h1234_5668;   // ^ 0x10 -> 0x1234_5678
        m0_mem_valid = 1'b1; m0_mem_addr = 32'h0000_0010; m0_mem_wstrb = 4'h0;
        expect_xfer(1'b0, 32'h1234_5678);
        #4;
        check("t1 request cycle grant", 32'(grant), 32'd0);
        check("t1 request cycle s_valid", 32'(s_mem_valid), 32'd0);
        tick(); #4;
        check("t1 grant", 32'(grant), 32'h1);
        check("t1 s_addr", s_mem_addr, 32'h0000_0010);
        check("t1 m0_ready", 32'(m0_mem_ready), 32'd1);
        tick();
        m0_mem_valid = 1'b0;
        #4;
        check("t1 release grant", 32'(grant), 32'd0);
        check("t1 release s_valid", 32'(s_mem_valid), 32'd0);

        // Test 2: simultaneous requests after reset, strict alternation
        do_reset();
        tick();
        slave_rdata = 32'hA5A5_0000;
        m0_mem_valid = 1'b1; m0_mem_addr = 32'h0000_0200;
        m1_mem_valid = 1'b1; m1_mem_addr = 32'h0000_0304;
        expect_xfer(1'b0, 32'hA5A5_0200);
        expect_xfer(1'b1, 32'hA5A5_0304);
        expect_xfer(1'b0, 32'hA5A5_0200);
        expect_xfer(1'b1, 32'hA5A5_0304);
        seen = 0; n = 0; last_cyc = 0;
        while (seen < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (m0_mem_ready || m1_mem_ready) begin
                check("t2 alternating grant", 32'(grant), (seen % 2 == 0) ? 32'h1 : 32'h2);
                if (seen > 0) check("t2 back-to-back spacing", 32'(cyc - last_cyc), 32'd3);
                last_cyc = cyc;
                seen++;
            end
        end
        check("t2 completions seen", 32'(seen), 32'd4);
        tick();
        m0_mem_valid = 1'b0;
        m1_mem_valid = 1'b0;
        tick();

        // Test 3: m1 write with 3 wait states
        slave_wait = 3;
        slave_rdata = 32'd0;
        m1_mem_valid = 1'b1; m1_mem_addr = 32'h0000_0100;
        m1_mem_wstrb = 4'b0011; m1_mem_wdata = 32'hAABB_CCDD; m1_mem_instr = 1'b0;
        expect_xfer(1'b1, 32'h0000_0100);
        for (int k = 1; k <= 4; k++) begin
            tick(); #4;
            check("t3 s mirrors m1", {s_mem_valid, 3'b000, s_mem_wstrb, s_mem_addr[23:0]}, 32'h8300_0100);
            check("t3 s_wdata", s_mem_wdata, 32'hAABB_CCDD);
            check("t3 readies", 32'({m0_mem_ready, m1_mem_ready}), (k == 4) ? 32'd1 : 32'd0);
        end
        tick();
        m1_mem_valid = 1'b0; m1_mem_wstrb = 4'h0;
        tick();

        // Test 4: m0 holds valid one cycle past ready
        slave_wait = 0;
        m0_mem_valid = 1'b1; m0_mem_addr = 32'h0000_0020;
        expect_xfer(1'b0, 32'h0000_0020);
        acc0 = slave_acc;
        tick();
        tick(); #4;
        check("t4 release s_valid", 32'(s_mem_valid), 32'd0);
        check("t4 release grant", 32'(grant), 32'd0);
        tick();
        m0_mem_valid = 1'b0;
        tick(); tick(); #4;
        check("t4 single slave access", 32'(slave_acc - acc0), 32'd1);

        // Test 5: reset during a stalled GNT1
        tick();
        slave_wait = 1000;
        m1_mem_valid = 1'b1; m1_mem_addr = 32'h0000_0040;
        tick(); #4;
        check("t5 granted m1", 32'(grant), 32'h2);
        check("t5 s_valid before reset", 32'(s_mem_valid), 32'd1);
        #2;
        reset = 1'b1;
        m1_mem_valid = 1'b0;
        #1;
        check("t5 async grant", 32'(grant), 32'd0);
        check("t5 async s_valid", 32'(s_mem_valid), 32'd0);
        check("t5 async readies", 32'({m0_mem_ready, m1_mem_ready}), 32'd0);
        tick();
        reset = 1'b0;
        slave_wait = 0;
        tick();
        m0_mem_valid = 1'b1; m0_mem_addr = 32'h0000_0080;
        expect_xfer(1'b0, 32'h0000_0080);
        #4;
        check("t5 post-reset idle grant", 32'(grant), 32'd0);
        tick(); #4;
        check("t5 post-reset grant", 32'(grant), 32'h1);
        tick();
        m0_mem_valid = 1'b0;
        tick();

`ifdef ARB_TIMEOUT_EN
        // Test 6: forced completion of a stalled m0, then m1 served
        slave_wait = 1000;
        m0_mem_valid = 1'b1; m0_mem_addr = 32'h0000_0300;
        expect_xfer(1'b0, 32'hDEAD_BEEF);
        gc = 0; n = 0; seen = 0;
        while (seen == 0 && n < 40) begin
            @(negedge clk);
            n++;
            if (grant == 2'b01) gc++;
            if (m0_mem_ready) begin
                seen = 1;
                check("t6 timeout_err at forced ready", 32'(timeout_err), 32'd1);
                check("t6 s_valid at forced ready", 32'(s_mem_valid), 32'd0);
            end
        end
        check("t6 grant cycles to timeout", 32'(gc), 32'd8);
        tick();
        m0_mem_valid = 1'b0;
        slave_wait = 0;
        m1_mem_valid = 1'b1; m1_mem_addr = 32'h0000_0400;
        expect_xfer(1'b1, 32'h0000_0400);
        n = 0; seen = 0;
        while (seen == 0 && n < 20) begin
            @(negedge clk);
            n++;
            if (m1_mem_ready) seen = 1;
        end
        check("t6 m1 served after timeout", 32'(seen), 32'd1);
        tick();
        m1_mem_valid = 1'b0;
        tick(); tick(); #4;
        check("t6 timeout pulses", 32'(tmo_pulses), 32'd1);
`else
        gc = 0;
        tick(); tick(); #4;
        check("timeout_err never pulses", 32'(tmo_pulses + gc), 32'd0);
`endif

        check("scoreboard drained", 32'(exp_m_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
